// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared constants, helpers and the per-channel state record
// for the clk_div_bank divider bank.
//   MIN_DIV          smallest legal divide ratio
//   PKG_DIV_W        width of a divide ratio (and of the period counter)
//   PKG_LOCK_PERIODS default number of settled periods before lock
//   ch_idx_w()       width of a channel index for n channels
//   lock_cnt_w()     width of a counter saturating at a given period count
//   ch_state_t       per-channel register state
package clk_div_pkg;

    localparam int MIN_DIV          = 2;
    localparam int PKG_DIV_W        = 16;
    localparam int PKG_LOCK_PERIODS = 4;

    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int lock_cnt_w(input int periods);
        return $clog2(periods + 1);
    endfunction

    localparam int PKG_LOCK_W = lock_cnt_w(PKG_LOCK_PERIODS);

    typedef struct packed {
        logic [PKG_DIV_W-1:0]  cnt;
        logic [PKG_DIV_W-1:0]  active_div;
        logic [PKG_DIV_W-1:0]  shadow_div;
        logic                  pend;
        logic [PKG_LOCK_W-1:0] lock_cnt;
    } ch_state_t;

endpackage

// File: rtl/clk_div_bank_channel.sv
// clk_div_channel: one divider channel of the bank.
//   refclk, rst_n    clock and synchronous active-low reset
//   en               run enable (level)
//   wr, wr_div       accepted configuration write and its ratio
//   tick             one-cycle pulse in the first cycle of each period
//   div_out          square wave, high for ceil(D/2) cycles of each period
//   pend             a new ratio is waiting to be applied
//   stable           no pending ratio and enough settled periods seen
// The ratio is double-buffered: writes land in shadow_div and are copied to
// active_div only at a period boundary, when the channel starts, or while
// it is stopped, so a running period is never cut short or stretched.
module clk_div_channel
    import clk_div_pkg::*;
#(
    parameter int DEFAULT_DIV  = 4,
    parameter int LOCK_PERIODS = PKG_LOCK_PERIODS
) (
    input  logic                 refclk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 wr,
    input  logic [PKG_DIV_W-1:0] wr_div,
    output logic                 tick,
    output logic                 div_out,
    output logic                 pend,
    output logic                 stable
);

    localparam logic [PKG_LOCK_W-1:0] LOCK_MAX = PKG_LOCK_W'(LOCK_PERIODS);
    localparam logic [PKG_DIV_W-1:0]  DEF_DIV  = PKG_DIV_W'(DEFAULT_DIV);

    ch_state_t            st;
    ch_state_t            st_nxt;
    logic                 en_q;
    logic                 start;
    logic                 wrap;
    logic                 apply;
    logic                 tick_nxt;
    logic                 div_nxt;
    logic [PKG_DIV_W:0]   half;

    assign start = en && !en_q;
    assign wrap  = en && en_q && (st.cnt == st.active_div - PKG_DIV_W'(1));
    // A stopped channel (or one just starting) has no period in flight, so
    // a pending ratio can be taken over straight away.
    assign apply = st.pend && (!en || start || wrap);

    always_comb begin
        st_nxt   = st;
        tick_nxt = 1'b0;
        div_nxt  = 1'b0;
        half     = '0;

        if (apply) begin
            st_nxt.active_div = st.shadow_div;
            st_nxt.pend       = 1'b0;
        end

        if (!en || start || wrap) begin
            st_nxt.cnt = '0;
        end else begin
            st_nxt.cnt = st.cnt + PKG_DIV_W'(1);
        end

        if (!en || start || apply) begin
            st_nxt.lock_cnt = '0;
        end else if (wrap && (st.lock_cnt != LOCK_MAX)) begin
            st_nxt.lock_cnt = st.lock_cnt + PKG_LOCK_W'(1);
        end

        // The bank only asserts wr when pend is clear, so this never
        // collides with an apply on the same edge.
        if (wr) begin
            st_nxt.shadow_div = wr_div;
            st_nxt.pend       = 1'b1;
            st_nxt.lock_cnt   = '0;
        end

        // One extra bit keeps (D+1) from wrapping at the largest ratio.
        half = ({1'b0, st_nxt.active_div} + (PKG_DIV_W + 1)'(1)) >> 1;
        if (en) begin
            tick_nxt = (st_nxt.cnt == '0);
            div_nxt  = ({1'b0, st_nxt.cnt} < half);
        end
    end

    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            st      <= '{cnt: '0, active_div: DEF_DIV, shadow_div: DEF_DIV,
                         pend: 1'b0, lock_cnt: '0};
            en_q    <= 1'b0;
            tick    <= 1'b0;
            div_out <= 1'b0;
        end else begin
            st      <= st_nxt;
            en_q    <= en;
            tick    <= tick_nxt;
            div_out <= div_nxt;
        end
    end

    assign pend   = st.pend;
    assign stable = !st.pend && (st.lock_cnt == LOCK_MAX);

endmodule

// File: rtl/clk_div_bank.sv
// clk_div_bank: run-time programmable bank of NUM_CH clock-enable dividers.
//   refclk, rst_n    clock and synchronous active-low reset
//   ch_en            per-channel run enable
//   cfg_valid/ready  ratio-update handshake; ready is combinational
//   cfg_ch, cfg_div  target channel and requested ratio
//   cfg_err          one-cycle pulse for a completed illegal request
//   tick, div_out    per-channel period strobe and square wave
//   locked           every enabled channel settled on its ratio
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter int NUM_CH       = 5,
    parameter int DIV_W        = PKG_DIV_W,
    parameter int DEFAULT_DIV  = 4,
    parameter int LOCK_PERIODS = PKG_LOCK_PERIODS,
    localparam int CH_W        = ch_idx_w(NUM_CH)
) (
    input  logic              refclk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] div_out,
    output logic              locked
);

    logic [NUM_CH-1:0] pend;
    logic [NUM_CH-1:0] stable;
    logic [NUM_CH-1:0] wr;
    logic [NUM_CH-1:0] en_q;
    logic              cfg_illegal;
    logic              pend_sel;
    logic              fire_legal;
    logic              lock_nxt;

    assign cfg_illegal = (32'(cfg_ch) >= 32'(NUM_CH)) ||
                         (cfg_div < DIV_W'(MIN_DIV));

    always_comb begin
        pend_sel = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                pend_sel = pend[i];
            end
        end
    end

    // Illegal requests are always accepted so the requester is never stuck.
    assign cfg_ready  = cfg_illegal || !pend_sel;
    assign fire_legal = cfg_valid && cfg_ready && !cfg_illegal;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign wr[i] = fire_legal && (cfg_ch == CH_W'(i));

        clk_div_channel #(
            .DEFAULT_DIV  (DEFAULT_DIV),
            .LOCK_PERIODS (LOCK_PERIODS)
        ) u_ch (
            .refclk  (refclk),
            .rst_n   (rst_n),
            .en      (ch_en[i]),
            .wr      (wr[i]),
            .wr_div  (cfg_div),
            .tick    (tick[i]),
            .div_out (div_out[i]),
            .pend    (pend[i]),
            .stable  (stable[i])
        );
    end

    // Any enable change or accepted update forces one unlocked cycle, even
    // when the remaining channels are all settled.
    assign lock_nxt = (|ch_en) && (ch_en == en_q) && !fire_legal &&
                      (&(stable | ~ch_en));

    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            cfg_err <= 1'b0;
            locked  <= 1'b0;
            en_q    <= '0;
        end else begin
            cfg_err <= cfg_valid && cfg_illegal;
            locked  <= lock_nxt;
            en_q    <= ch_en;
        end
    end

endmodule

// File: doc/clk_div_bank.md
Name: clk_div_bank

Overview:
- Parametrised, run-time programmable clock-enable/divider bank for the frequency meter.
- Derives NUM_CH independent divided strobes and square waves from one reference clock, each with its own divide ratio.
- Divide-ratio updates are glitch-free (applied only at period boundaries).
- Aggregate lock flag tells the measurement logic when every enabled channel has settled.
- Outputs are data-path signals (tick enables, square waves), not clock-tree nets.

Parameters:
- NUM_CH, 5, number of divider channels.
- DIV_W, 16, width of a divide ratio; legal ratio 2..2^DIV_W-1.
- DEFAULT_DIV, 4, ratio loaded into every channel at reset.
- LOCK_PERIODS, 4, full periods each enabled channel must complete after a change before lock asserts.

Ports:
- refclk  in  1  single clock for the whole block.
- rst_n  in  1  reset, synchronous, active-low.
- ch_en  in  NUM_CH  per-channel run enable, level.
- cfg_valid  in  1  configuration request.
- cfg_ready  out  1  combinational; high when the channel addressed by cfg_ch has no pending update.
- cfg_ch  in  $clog2(NUM_CH)  target channel; values >= NUM_CH are illegal.
- cfg_div  in  DIV_W  requested divide ratio.
- cfg_err  out  1  one-cycle pulse when a handshake carries illegal data.
- tick  out  NUM_CH  one-cycle pulse at the start of each channel period.
- div_out  out  NUM_CH  square wave per channel.
- locked  out  1  all enabled channels stable.

Behaviour:
- Reset (rst_n low at a refclk edge):
  - active ratio = DEFAULT_DIV and pending flag clear on every channel; counters = 0.
  - tick, div_out, cfg_err and locked = 0.
  - cfg_ready = 1 the cycle after reset releases.
  - Reset mid-period or with an update pending discards the pending ratio.
- Per-channel counter cnt:
  - Runs 0..D-1 while ch_en is high (D = active ratio).
  - tick register = 1 in the cycle where cnt == 0.
  - div_out register = (cnt < ceil(D/2)). Odd D gives a high phase one cycle longer than the low phase.
- Enable: ch_en rising, sampled at edge k, gives cnt = 0 and tick = 1 in cycle k+1. The period therefore starts one cycle after ch_en is sampled.
- Disable: ch_en low, sampled, gives cnt = 0 and tick = div_out = 0 next cycle. A pending ratio is applied immediately on disable.
- Handshake:
  - Transfer occurs when cfg_valid && cfg_ready.
  - A legal transfer writes the shadow ratio and sets pend[cfg_ch].
  - Requester holds cfg_valid and data stable until ready.
- Illegal transfer (cfg_div < 2, or cfg_ch >= NUM_CH):
  - cfg_ready is 1 for the illegal cycle and the transfer completes.
  - Nothing is stored; cfg_err = 1 for one cycle.
- Applying a pending update:
  - Enabled channel: applied at the edge where cnt == D-1, so the next period (tick) uses the new ratio. No truncated or stretched period occurs.
  - Disabled channel: applied on the next edge.
  - pend clears on the same edge it is applied.
- Same-cycle events: accept-while-applying on the same channel is impossible because ready is low while pend is set. Updates to different channels are independent.
- Lock tracking:
  - Each channel holds a stable-period counter, saturating at LOCK_PERIODS.
  - Cleared on enable rise, on handshake acceptance and on application of an update; incremented at each period end.
  - locked = 1 (registered) when at least one channel is enabled and every enabled channel has pend == 0 and count == LOCK_PERIODS.
  - locked drops the cycle after any accepted cfg or any ch_en change.
  - Disabled channels are ignored for lock.
- Widths:
  - cnt is DIV_W bits; ceil(D/2) is computed as (D+1)>>1 at DIV_W+1 bits, with no overflow at D = 2^DIV_W-1.
  - Lock counter is $clog2(LOCK_PERIODS+1) bits.

Decomposition:
- Package clk_div_pkg holds:
  - MIN_DIV = 2
  - channel-index width function
  - lock-counter width
  - a channel-state struct (cnt, active_div, shadow_div, pend, lock_cnt)
- One sub-module, clk_div_channel: counter, shadow/apply logic, tick/div_out, stable counter.
- Top level clk_div_bank holds: NUM_CH instances, cfg decode/ready mux, error pulse, lock reduction.

Test Plan:
- Reset, then ch_en = 5'b00001 and defaults -> ch0 tick every 4 cycles, first tick 1 cycle after enable; div_out 1,1,0,0 repeating; locked rises after 4 periods + 1 cycle.
- cfg ch1 div=7 with ch1 running at 4 -> current 4-cycle period completes intact; then period 7 with div_out high 4, low 3; cfg_ready for ch1 low until applied.
- cfg div=1 and separately cfg_ch=6 -> cfg_err pulses once each; ratios unchanged; locked unaffected.
- Back-to-back cfg to ch2 (div=10, then div=3) -> second request stalls (cfg_ready=0) until the first applies at the period end; then 3 is applied after one 10-cycle period.
- Disable ch3 while pend set (div=9), re-enable -> first period after re-enable is 9 cycles; locked low until 4 stable periods.
- Assert rst_n=0 mid-period with pending updates -> next cycle all outputs 0; after release all channels at DEFAULT_DIV and pend clear.
